key_debounce16: RTL

KEY_DEBOUNCE16 -- requirements
Module: key_debounce16

---
 rtl/key_deb_pkg.sv | 16 +
 rtl/sync2.sv | 34 +++
 rtl/key_debounce16.sv | 136 +++++++++++++
 3 files changed

// File: rtl/key_deb_pkg.sv
// -----------------------------------------------------------------------------
// key_deb_pkg
// Shared constants for the 16-key debouncer (key_debounce16) and its helpers.
//   KEY_W             : number of keys
//   KEY_IDLE          : key vector with no key pressed (active-low keys)
//   RPT_W             : width of the auto-repeat counter
//   DEB_CYCLES_DEF    : default debounce window in clocks
//   REPEAT_CYCLES_DEF : default auto-repeat period in clocks
// -----------------------------------------------------------------------------
package key_deb_pkg;
  localparam int                 KEY_W             = 16;
  localparam logic [KEY_W-1:0]   KEY_IDLE          = 16'hFFFF;
  localparam int                 RPT_W             = 24;
  localparam int                 DEB_CYCLES_DEF    = 50000;
  localparam int                 REPEAT_CYCLES_DEF = 5000000;
endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a vector of asynchronous inputs. Both stages
// reset to all-ones so an idle active-low input never shows a false edge
// when reset is released.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset (flops go to all-ones)
//   i_d   : asynchronous input vector
//   o_q   : synchronized output vector (two clocks of latency)
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/key_debounce16.sv
// -----------------------------------------------------------------------------
// key_debounce16
// Debounces 16 active-low keys with one shared stability window and reports
// press events as a one-clock pulse plus a mask of the keys just pressed.
// Optional auto-repeat is built only when the macro KEY_DEB_REPEAT_EN is
// defined; otherwise REPEAT_CYCLES is accepted but unused by the logic.
// Parameters:
//   DEB_CYCLES    : stable clocks needed to commit a change (2..65535)
//   REPEAT_CYCLES : auto-repeat period in clocks (2..2^24-1)
// Ports:
//   clk        : clock, all state changes on rising edge
//   rst_n      : asynchronous active-low reset
//   key_raw_n  : raw bouncing keys, 0 = pressed
//   key_n      : debounced registered keys, 0 = pressed
//   press_vld  : one-clock press event pulse
//   press_mask : active-high keys causing the event, 0 when press_vld=0
// -----------------------------------------------------------------------------
module key_debounce16
  import key_deb_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_raw_n,
  output logic [KEY_W-1:0] key_n,
  output logic             press_vld,
  output logic [KEY_W-1:0] press_mask
);
  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Elaboration-time range checks on the configuration.
  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("key_debounce16: DEB_CYCLES out of range 2..65535");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > (1 << RPT_W) - 1) begin : g_bad_rpt
    $error("key_debounce16: REPEAT_CYCLES out of range 2..2^24-1");
  end

  logic [KEY_W-1:0] w_sync_n;
  logic [KEY_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_key_n;
  logic             w_commit;
  logic [KEY_W-1:0] w_new_press;
  logic             r_press_vld;
  logic [KEY_W-1:0] r_press_mask;

  // Synchronizer stage
  sync2 #(
    .W (KEY_W)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (key_raw_n),
    .o_q   (w_sync_n)
  );

  // Debounce stage: one window shared by all keys
  always_comb begin
    w_commit    = (w_sync_n == r_cand) && (r_cand != r_key_n) && (r_cnt == CNT_LAST);
    // Keys going 1->0 in the committed vector; releases contribute nothing.
    w_new_press = r_key_n & ~r_cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand  <= KEY_IDLE;
      r_cnt   <= '0;
      r_key_n <= KEY_IDLE;
    end else if (w_sync_n != r_cand) begin
      // Any change on any key restarts the window for every key.
      r_cand <= w_sync_n;
      r_cnt  <= '0;
    end else if (r_cand != r_key_n) begin
      if (r_cnt == CNT_LAST) begin
        r_key_n <= r_cand;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Event stage
`ifdef KEY_DEB_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt        <= '0;
      r_press_vld  <= 1'b0;
      r_press_mask <= '0;
    end else if (w_commit) begin
      // A commit outranks a coinciding repeat expiry: one pulse only.
      r_rpt        <= '0;
      r_press_vld  <= |w_new_press;
      r_press_mask <= w_new_press;
    end else if (r_key_n == KEY_IDLE) begin
      r_rpt        <= '0;
      r_press_vld  <= 1'b0;
      r_press_mask <= '0;
    end else if (r_rpt == RPT_LAST) begin
      r_rpt        <= '0;
      r_press_vld  <= 1'b1;
      r_press_mask <= ~r_key_n;
    end else begin
      r_rpt        <= r_rpt + RPT_W'(1);
      r_press_vld  <= 1'b0;
      r_press_mask <= '0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press_vld  <= 1'b0;
      r_press_mask <= '0;
    end else if (w_commit) begin
      r_press_vld  <= |w_new_press;
      r_press_mask <= w_new_press;
    end else begin
      r_press_vld  <= 1'b0;
      r_press_mask <= '0;
    end
  end
`endif

  assign key_n      = r_key_n;
  assign press_vld  = r_press_vld;
  assign press_mask = r_press_mask;
endmodule
